// File: rtl/dcache_axi.sv
// AXI4 master bridge for a data cache: one outstanding transaction at a time,
// serving line refills, line writebacks and single-beat uncached accesses.
module dcache_axi #(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'b0001
) (
    input  logic                     clk,
    input  logic                     rst,
    // dcache side
    input  logic                     cache_rreq,
    input  logic                     cache_wreq,
    input  logic                     uncache_rreq,
    input  logic                     uncache_wreq,
    input  logic [31:0]              dc_bus_addr_i,
    input  logic [3:0]               dc_bus_wen_i,
    input  logic [31:0]              dc_bus_wdata_i,
    input  logic [1:0]               dc_bus_load_size_i,
    input  logic [1:0]               dc_bus_store_size_i,
    input  logic [LINE_WORDS*32-1:0] cacheline_wdata_i,
    output logic                     rend,
    output logic                     wend,
    output logic                     write_ok,
    output logic [LINE_WORDS*32-1:0] cacheline_rdata_o,
    output logic [31:0]              dc_uc_data_o,
    // AR channel
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    // R channel
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    // AW channel
    output logic [3:0]               awid,
    output logic [31:0]              awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     awvalid,
    input  logic                     awready,
    // W channel
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    // B channel
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam int          IDX_W     = $clog2(LINE_WORDS);
    localparam logic [7:0]  BURST_LEN = 8'(LINE_WORDS - 1);
    localparam logic [31:0] LINE_MASK = ~32'(LINE_WORDS * 4 - 1);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [7:0]                   cnt_q, cnt_d;
    logic [31:0]                  addr_q, addr_d;
    logic [3:0]                   wen_q, wen_d;
    logic [31:0]                  wdata_q, wdata_d;
    logic [1:0]                   load_size_q, load_size_d;
    logic [1:0]                   store_size_q, store_size_d;
    logic                         cached_q, cached_d;
    logic                         is_wr_q, is_wr_d;
    logic                         write_ok_q, write_ok_d;
    logic [LINE_WORDS-1:0][31:0]  vline_q, vline_d;
    logic [LINE_WORDS-1:0][31:0]  rline_q, rline_d;
    logic [31:0]                  uc_q, uc_d;

    logic [IDX_W-1:0]             idx;
    logic [7:0]                   xfer_len;
    logic                         unused_resp;

    // Responses and IDs carry nothing this master acts on.
    assign unused_resp = ^{rid, rresp, bresp};

    assign idx      = cnt_q[IDX_W-1:0];
    assign xfer_len = cached_q ? BURST_LEN : 8'd0;

    // Channel outputs are decoded from the state and the latched request.
    assign arid     = AXI_ID;
    assign araddr   = cached_q ? (addr_q & LINE_MASK) : addr_q;
    assign arlen    = xfer_len;
    assign arsize   = cached_q ? 3'b010 : {1'b0, load_size_q};
    assign arburst  = 2'b01;
    assign arvalid  = (state_q == RD_ADDR);
    assign rready   = (state_q == RD_DATA);

    assign awid     = AXI_ID;
    assign awaddr   = cached_q ? (addr_q & LINE_MASK) : addr_q;
    assign awlen    = xfer_len;
    assign awsize   = cached_q ? 3'b010 : {1'b0, store_size_q};
    assign awburst  = 2'b01;
    assign awvalid  = (state_q == WR_ADDR);

    assign wvalid   = (state_q == WR_DATA);
    assign wdata    = cached_q ? vline_q[idx] : wdata_q;
    assign wstrb    = cached_q ? 4'hF : wen_q;
    assign wlast    = wvalid && (cnt_q == xfer_len);
    assign bready   = (state_q == WR_RESP);

    assign rend              = (state_q == DONE) && !is_wr_q;
    assign wend              = (state_q == DONE) && is_wr_q;
    assign write_ok          = write_ok_q;
    assign cacheline_rdata_o = rline_q;
    assign dc_uc_data_o      = uc_q;

    // Next-state, request latching and beat bookkeeping.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        load_size_d  = load_size_q;
        store_size_d = store_size_q;
        cached_d     = cached_q;
        is_wr_d      = is_wr_q;
        vline_d      = vline_q;
        rline_d      = rline_q;
        uc_d         = uc_q;
        write_ok_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cache_wreq || uncache_wreq || cache_rreq || uncache_rreq) begin
                    addr_d       = dc_bus_addr_i;
                    wen_d        = dc_bus_wen_i;
                    wdata_d      = dc_bus_wdata_i;
                    load_size_d  = dc_bus_load_size_i;
                    store_size_d = dc_bus_store_size_i;
                    vline_d      = cacheline_wdata_i;
                    cnt_d        = 8'd0;
                    if (cache_wreq) begin
                        cached_d = 1'b1;
                        is_wr_d  = 1'b1;
                        state_d  = WR_ADDR;
                    end else if (uncache_wreq) begin
                        cached_d = 1'b0;
                        is_wr_d  = 1'b1;
                        state_d  = WR_ADDR;
                    end else if (cache_rreq) begin
                        cached_d = 1'b1;
                        is_wr_d  = 1'b0;
                        state_d  = RD_ADDR;
                    end else begin
                        cached_d = 1'b0;
                        is_wr_d  = 1'b0;
                        state_d  = RD_ADDR;
                    end
                end
            end
            RD_ADDR: if (arready) state_d = RD_DATA;
            RD_DATA: begin
                if (rvalid) begin
                    if (cached_q) rline_d[idx] = rdata;
                    else          uc_d         = rdata;
                    cnt_d = cnt_q + 8'd1;
                    if (rlast) state_d = DONE;
                end
            end
            WR_ADDR: if (awready) state_d = WR_DATA;
            WR_DATA: begin
                if (wready) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == xfer_len) begin
                        write_ok_d = 1'b1;
                        state_d    = WR_RESP;
                    end
                end
            end
            WR_RESP: if (bvalid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            addr_q       <= 32'd0;
            wen_q        <= 4'd0;
            wdata_q      <= 32'd0;
            load_size_q  <= 2'd0;
            store_size_q <= 2'd0;
            cached_q     <= 1'b0;
            is_wr_q      <= 1'b0;
            write_ok_q   <= 1'b0;
            // NOTE: line buffers are reset too, because their contents drive outputs that must read 0 in reset.
            vline_q      <= '0;
            rline_q      <= '0;
            uc_q         <= 32'd0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            load_size_q  <= load_size_d;
            store_size_q <= store_size_d;
            cached_q     <= cached_d;
            is_wr_q      <= is_wr_d;
            write_ok_q   <= write_ok_d;
            vline_q      <= vline_d;
            rline_q      <= rline_d;
            uc_q         <= uc_d;
        end
    end

endmodule

// File: tb/tb_dcache_axi.sv
// Self-checking bench for dcache_axi: the bench plays the AXI slave and the
// dcache, and checks every channel field and result against values it derives
// from the request it issued.
module tb_dcache_axi;

    localparam int         LW = 8;
    localparam logic [3:0] ID = 4'b0001;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cache_rreq, cache_wreq, uncache_rreq, uncache_wreq;
    logic [31:0]          dc_bus_addr_i, dc_bus_wdata_i;
    logic [3:0]           dc_bus_wen_i;
    logic [1:0]           dc_bus_load_size_i, dc_bus_store_size_i;
    logic [LW*32-1:0]     cacheline_wdata_i;
    logic                 rend, wend, write_ok;
    logic [LW*32-1:0]     cacheline_rdata_o;
    logic [31:0]          dc_uc_data_o;
    logic [3:0]           arid, awid, rid;
    logic [31:0]          araddr, awaddr, rdata, wdata;
    logic [7:0]           arlen, awlen;
    logic [2:0]           arsize, awsize;
    logic [1:0]           arburst, awburst, rresp, bresp;
    logic                 arvalid, arready, rlast, rvalid, rready;
    logic                 awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]           wstrb;

    int                   n_checks = 0;
    int                   n_fail   = 0;
    logic [31:0]          exp_line [LW];
    logic [31:0]          exp_uc;

    always #5 clk = ~clk;

    dcache_axi #(.LINE_WORDS(LW), .AXI_ID(ID)) dut (
        .clk(clk), .rst(rst),
        .cache_rreq(cache_rreq), .cache_wreq(cache_wreq),
        .uncache_rreq(uncache_rreq), .uncache_wreq(uncache_wreq),
        .dc_bus_addr_i(dc_bus_addr_i), .dc_bus_wen_i(dc_bus_wen_i),
        .dc_bus_wdata_i(dc_bus_wdata_i),
        .dc_bus_load_size_i(dc_bus_load_size_i), .dc_bus_store_size_i(dc_bus_store_size_i),
        .cacheline_wdata_i(cacheline_wdata_i),
        .rend(rend), .wend(wend), .write_ok(write_ok),
        .cacheline_rdata_o(cacheline_rdata_o), .dc_uc_data_o(dc_uc_data_o),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Hard stop in case some handshake never completes.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Both read-result outputs must match the model at all times.
    task automatic check_results(input string tag);
        for (int k = 0; k < LW; k++)
            check($sformatf("%s_line%0d", tag, k), cacheline_rdata_o[32*k +: 32], exp_line[k]);
        check({tag, "_uc"}, dc_uc_data_o, exp_uc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valids"}, 32'({arvalid, rready, awvalid, wvalid, wlast, bready}), 32'd0);
        check({tag, "_pulses"}, 32'({rend, wend, write_ok}), 32'd0);
        check({tag, "_araddr"}, araddr, 32'd0);
        check({tag, "_awaddr"}, awaddr, 32'd0);
        check({tag, "_wdata"}, wdata, 32'd0);
        check({tag, "_line_any"}, 32'(|cacheline_rdata_o), 32'd0);
        check({tag, "_uc"}, dc_uc_data_o, 32'd0);
    endtask

    // mode 0: random data, 1: word k = k, 2: every beat = fixed
    task automatic do_read(input bit cached, input logic [31:0] addr, input logic [1:0] size,
                           input int ar_delay, input int mode, input logic [31:0] fixed);
        int          nb;
        int          n;
        logic [31:0] data [LW];
        nb = cached ? LW : 1;
        for (int k = 0; k < nb; k++)
            data[k] = (mode == 1) ? 32'(k) : (mode == 2) ? fixed : $urandom;
        cache_rreq         = cached;
        uncache_rreq       = !cached;
        dc_bus_addr_i      = addr;
        dc_bus_load_size_i = size;
        for (n = 0; n < 50 && !arvalid; n++) @(negedge clk);
        check("rd_arvalid", 32'(arvalid), 32'd1);
        check("rd_awvalid_quiet", 32'(awvalid), 32'd0);
        check("rd_araddr", araddr, cached ? (addr & ~32'(LW*4 - 1)) : addr);
        check("rd_arlen", 32'(arlen), cached ? 32'(LW - 1) : 32'd0);
        check("rd_arsize", 32'(arsize), cached ? 32'd2 : 32'(size));
        check("rd_arburst", 32'(arburst), 32'd1);
        check("rd_arid", 32'(arid), 32'(ID));
        // Stray R beats while the address is still pending must be ignored.
        repeat (ar_delay) begin
            rvalid = 1'b1; rlast = 1'b1; rdata = 32'hDEAD_BEEF;
            rid = 4'($urandom); rresp = 2'($urandom);
            @(negedge clk);
            check("rd_ar_hold", 32'({arvalid, rready}), 32'b10);
        end
        rvalid = 1'b0; rlast = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("rd_rready", 32'({arvalid, rready}), 32'b01);
        for (int k = 0; k < nb; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("rd_no_early_rend", 32'(rend), 32'd0);
            end
            rvalid = 1'b1; rdata = data[k]; rlast = (k == nb - 1);
            rresp = 2'($urandom); rid = 4'($urandom);
            @(negedge clk);
            rvalid = 1'b0; rlast = 1'b0;
        end
        check("rd_rend", 32'(rend), 32'd1);
        check("rd_rready_done", 32'(rready), 32'd0);
        if (cached) for (int k = 0; k < LW; k++) exp_line[k] = data[k];
        else exp_uc = data[0];
        check_results("rd");
        // Request is still held here; it must not start a second transaction.
        @(negedge clk);
        check("rd_rend_once", 32'(rend), 32'd0);
        check("rd_not_reissued", 32'({arvalid, awvalid}), 32'd0);
        cache_rreq = 1'b0; uncache_rreq = 1'b0;
    endtask

    task automatic do_write(input bit cached, input logic [31:0] addr, input logic [3:0] wen,
                            input logic [1:0] size, input int aw_delay, input int b_delay,
                            input bit toggle);
        int          nb;
        int          n;
        int          beat;
        logic [31:0] line [LW];
        logic [31:0] wd;
        nb = cached ? LW : 1;
        wd = $urandom;
        for (int k = 0; k < LW; k++) begin
            line[k] = $urandom;
            cacheline_wdata_i[32*k +: 32] = line[k];
        end
        cache_wreq          = cached;
        uncache_wreq        = !cached;
        dc_bus_addr_i       = addr;
        dc_bus_wen_i        = wen;
        dc_bus_wdata_i      = wd;
        dc_bus_store_size_i = size;
        for (n = 0; n < 50 && !awvalid; n++) @(negedge clk);
        check("wr_awvalid", 32'(awvalid), 32'd1);
        check("wr_arvalid_quiet", 32'(arvalid), 32'd0);
        check("wr_awaddr", awaddr, cached ? (addr & ~32'(LW*4 - 1)) : addr);
        check("wr_awlen", 32'(awlen), cached ? 32'(LW - 1) : 32'd0);
        check("wr_awsize", 32'(awsize), cached ? 32'd2 : 32'(size));
        check("wr_awburst", 32'(awburst), 32'd1);
        check("wr_awid", 32'(awid), 32'(ID));
        // The request data was latched; scrambling the inputs must not matter.
        dc_bus_wdata_i    = ~wd;
        dc_bus_wen_i      = ~wen;
        cacheline_wdata_i = ~cacheline_wdata_i;
        repeat (aw_delay) begin
            wready = 1'b1;
            @(negedge clk);
            check("wr_aw_hold", 32'({awvalid, wvalid}), 32'b10);
        end
        wready  = 1'b0;
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        beat = 0;
        for (int c = 0; c < 200 && beat < nb; c++) begin
            check("wr_wvalid", 32'({awvalid, wvalid}), 32'b01);
            check("wr_wlast", 32'(wlast), 32'(beat == nb - 1));
            check("wr_no_early_ok", 32'(write_ok), 32'd0);
            wready = toggle ? 1'(c % 2) : 1'($urandom_range(0, 1));
            if (wready) begin
                check($sformatf("wr_wdata%0d", beat), wdata, cached ? line[beat] : wd);
                check("wr_wstrb", 32'(wstrb), cached ? 32'hF : 32'(wen));
                beat++;
            end
            @(negedge clk);
        end
        wready = 1'b0;
        check("wr_beats", 32'(beat), 32'(nb));
        check("wr_write_ok", 32'(write_ok), 32'd1);
        check("wr_bready", 32'({wvalid, bready}), 32'b01);
        repeat (b_delay) begin
            bresp = 2'($urandom);
            @(negedge clk);
            check("wr_ok_once", 32'(write_ok), 32'd0);
            check("wr_wait_b", 32'({bready, wend}), 32'b10);
        end
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        check("wr_wend", 32'(wend), 32'd1);
        check("wr_done_quiet", 32'({write_ok, rend, bready}), 32'd0);
        @(negedge clk);
        check("wr_wend_once", 32'(wend), 32'd0);
        check("wr_not_reissued", 32'({arvalid, awvalid}), 32'd0);
        cache_wreq = 1'b0; uncache_wreq = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        {cache_rreq, cache_wreq, uncache_rreq, uncache_wreq} = 4'b0;
        dc_bus_addr_i = '0; dc_bus_wdata_i = '0; dc_bus_wen_i = '0;
        dc_bus_load_size_i = '0; dc_bus_store_size_i = '0; cacheline_wdata_i = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0; bresp = '0;
        for (int k = 0; k < LW; k++) exp_line[k] = 32'd0;
        exp_uc = 32'd0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Cached refill with ramp data and a 2-cycle arready delay.
        do_read(1'b1, 32'h1000_0014, 2'd2, 2, 1, 32'd0);
        // Uncached byte load; refill line must be untouched.
        do_read(1'b0, 32'hBFAF_8003, 2'd0, 1, 2, 32'h0000_00A5);
        // Cached writeback with wready toggling every cycle.
        do_write(1'b1, 32'h0000_1234, 4'h0, 2'd2, 1, 2, 1'b1);
        // Uncached halfword store with partial strobes.
        do_write(1'b0, 32'hBFD0_0002, 4'b1100, 2'd1, 0, 0, 1'b0);

        // Writeback and refill requested together: write first, then read.
        cache_rreq = 1'b1;
        do_write(1'b1, 32'h2000_0040, 4'h0, 2'd2, 0, 1, 1'b0);
        do_read(1'b1, 32'h2000_0040, 2'd2, 0, 0, 32'd0);

        // Reset pulse in the middle of a refill, during beat 3.
        cache_rreq = 1'b1; dc_bus_addr_i = 32'h3000_0080;
        for (n = 0; n < 50 && !arvalid; n++) @(negedge clk);
        check("abort_arvalid", 32'(arvalid), 32'd1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rvalid = 1'b1; rdata = 32'(100 + k);
            @(negedge clk);
        end
        rdata = 32'd103;
        rst   = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b0; cache_rreq = 1'b0;
        for (int k = 0; k < LW; k++) exp_line[k] = 32'd0;
        exp_uc = 32'd0;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_rend", 32'({rend, wend, write_ok, arvalid}), 32'd0);
        end
        check_results("abort");
        do_read(1'b1, 32'h3000_0080, 2'd2, 1, 0, 32'd0);

        // Randomized mix of transactions.
        for (int t = 0; t < 20; t++) begin
            logic [31:0] a;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: do_read(1'b1, a, 2'd2, $urandom_range(0, 3), 0, 32'd0);
                1: do_read(1'b0, a, 2'($urandom_range(0, 2)), $urandom_range(0, 3), 0, 32'd0);
                2: do_write(1'b1, a, 4'h0, 2'd2, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
                default: do_write(1'b0, a, 4'($urandom), 2'($urandom_range(0, 2)),
                                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
